alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Decode-to-execute pipeline register that feeds the 32-bit ALU: src1, src2 and the 4-bit ALU_control.
- Accepts one decoded instruction per cycle through a valid/ready handshake.
- Resolves operand forwarding from the EX/MEM and MEM/WB stages and selects between the rt operand and an extended immediate.
- Holds the instruction while the ALU side stalls, and snoops writeback while holding so held operands stay current.

Parameters:
- DATA_W, 32, operand/result width (must match the ALU)
- REG_AW, 5, register-address width; register 0 is hardwired zero

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_rs_addr  in  REG_AW  rs index
- in_rt_addr  in  REG_AW  rt index
- in_rd_addr  in  REG_AW  destination index
- in_rs_data  in  DATA_W  register-file rs value
- in_rt_data  in  DATA_W  register-file rt value
- in_imm  in  16  instruction immediate
- in_alu_src  in  1  1: src2 = extended immediate
- in_sign_ext  in  1  1: sign-extend, 0: zero-extend
- in_alu_ctrl  in  4  ALU operation code
- in_reg_write  in  1  instruction writes rd
- flush  in  1  squash held and incoming instruction
- exmem_reg_write  in  1  EX/MEM writes a register
- exmem_rd_addr  in  REG_AW  EX/MEM destination
- exmem_result  in  DATA_W  EX/MEM ALU result
- memwb_reg_write  in  1  MEM/WB writes a register
- memwb_rd_addr  in  REG_AW  MEM/WB destination
- memwb_data  in  DATA_W  MEM/WB writeback value
- out_valid  out  1  ALU operands valid
- out_ready  in  1  execute side consumes this cycle
- src1  out  DATA_W  ALU source 1
- src2  out  DATA_W  ALU source 2
- ALU_control  out  4  ALU operation
- out_rd_addr  out  REG_AW  destination carried forward
- out_reg_write  out  1  write-enable carried forward
- out_store_data  out  DATA_W  forwarded rt value (store data)
- perf_issue_cnt  out  32  issued instructions (optional feature)
- perf_stall_cnt  out  32  hold cycles (optional feature)

Behaviour:
- Reset (rst_n low at a rising edge): all outputs and state go to 0; out_valid=0. in_ready reads 1 on the first cycle after reset.
- Reset overrides flush and capture, including mid-hold.
- in_ready = !out_valid || out_ready (combinational). Capture happens when in_valid && in_ready.
- Latency: 1 cycle from capture to out_valid=1.
- Forwarding is per operand (rs, rt) and applied at capture:
  - EX/MEM match (write set, addr equal, addr≠0) wins.
  - Otherwise MEM/WB match.
  - Otherwise register-file data.
  - Address 0 always yields 0, whatever the input data.
- src2 = in_alu_src ? ext(in_imm) : forwarded rt. out_store_data is always the forwarded rt.
- Extension: sign_ext copies imm[15] into bits 31:16; otherwise bits 31:16 are zero.
- Hold (out_valid && !out_ready):
  - All outputs are stable.
  - Each cycle, a MEM/WB write to a held rs/rt address (≠0) replaces src1 / out_store_data, and src2 when it came from rt (not the immediate).
  - EX/MEM is not snooped during hold.
- Pass-through: out_valid && out_ready && in_valid, with no flush, gives a back-to-back capture and no bubble.
- Consume without capture: out_valid && out_ready && !in_valid clears out_valid.
- Flush (sync):
  - Next cycle out_valid=0.
  - The incoming instruction is dropped, even though in_ready may read 1.
  - Flush beats capture and hold.
  - Other outputs keep their values; they are don't-care while out_valid=0.
- While out_valid=0, out_reg_write is forced 0.
- ALU_control codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100. Codes pass through unmodified.

Optional Feature:
- ALU_ISSUE_PERF_EN defined:
  - perf_issue_cnt increments on each cycle with out_valid && out_ready.
  - perf_stall_cnt increments on each hold cycle.
  - Both are 32-bit, wrap 0xFFFFFFFF→0, reset to 0, and are not cleared by flush.
- Undefined: both ports are tied to 0 and no counter logic exists.

Decomposition:
- Shared package alu_pkg:
  - ALU_control code constants.
  - DATA_W and REG_AW defaults.
  - Forward-select enum: FWD_RF, FWD_EXMEM, FWD_MEMWB.
- Sub-module fwd_sel:
  - Combinational priority mux for one operand.
  - Instantiated twice (rs, rt) and reused by the hold-snoop path with the EX/MEM match disabled.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with in_valid=1 → out_valid=0, src1=src2=0, in_ready=1 after release.
- Immediate: rs=3 (data 5), imm=0xFFF0, alu_src=1, sign_ext=1, ctrl=0010 → next cycle src1=5, src2=0xFFFFFFF0, ALU_control=0010. Repeat with sign_ext=0 → src2=0x0000FFF0.
- Forward priority: rs=7 with exmem(rd=7, 0xAAAA) and memwb(rd=7, 0xBBBB) both active → src1=0xAAAA. Same with rs=0 → src1=0.
- Hold snoop: capture rt=4 (rf 0x11), out_ready=0 for 3 cycles, memwb writes r4=0x22 in cycle 2 → src2 and out_store_data change to 0x22; in_ready=0 throughout; stall counter=3 if enabled.
- Flush: out_valid=1, flush=1 with in_valid=1 → next cycle out_valid=0 and out_reg_write=0; the following cycle accepts a new instruction normally.
- Throughput: out_ready=1, 10 back-to-back instructions → 10 consecutive out_valid cycles with no bubble; perf_issue_cnt=10 if enabled.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: default widths, ALU_control
// codes and the operand-forwarding source enumeration.
package alu_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_REG_AW = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_EXMEM,
        FWD_MEMWB
    } fwd_sel_e;

endpackage

// File: rtl/alu_issue_stage_fwd_sel.sv
// Combinational forwarding priority mux for one operand:
// EX/MEM beats MEM/WB beats register file; register 0 always reads zero.
module fwd_sel
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int REG_AW = ALU_REG_AW
) (
    input  logic [REG_AW-1:0] addr,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd_addr,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd_addr,
    input  logic [DATA_W-1:0] memwb_data,
    output logic [DATA_W-1:0] data
);

    fwd_sel_e sel;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sel = FWD_RF;
        if (addr != '0) begin
            if (exmem_reg_write && (exmem_rd_addr == addr)) begin
                sel = FWD_EXMEM;
            end else if (memwb_reg_write && (memwb_rd_addr == addr)) begin
                sel = FWD_MEMWB;
            end
        end
    end

    always_comb begin
        data = '0;
        unique case (sel)
            FWD_EXMEM: data = exmem_result;
            FWD_MEMWB: data = memwb_data;
            default:   data = (addr == '0) ? '0 : rf_data;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-to-execute register feeding the ALU, with forwarding, hold snooping and flush.
// Optional performance counters are built only when ALU_ISSUE_PERF_EN is defined.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int REG_AW = ALU_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rs_addr,
    input  logic [REG_AW-1:0] in_rt_addr,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic [15:0]       in_imm,
    input  logic              in_alu_src,
    input  logic              in_sign_ext,
    input  logic [3:0]        in_alu_ctrl,
    input  logic              in_reg_write,
    input  logic              flush,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd_addr,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd_addr,
    input  logic [DATA_W-1:0] memwb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] src1,
    output logic [DATA_W-1:0] src2,
    output logic [3:0]        ALU_control,
    output logic [REG_AW-1:0] out_rd_addr,
    output logic              out_reg_write,
    output logic [DATA_W-1:0] out_store_data,
    output logic [31:0]       perf_issue_cnt,
    output logic [31:0]       perf_stall_cnt
);

    logic              valid_q,     valid_d;
    logic [DATA_W-1:0] src1_q,      src1_d;
    logic [DATA_W-1:0] src2_q,      src2_d;
    logic [DATA_W-1:0] store_q,     store_d;
    logic [3:0]        ctrl_q,      ctrl_d;
    logic [REG_AW-1:0] rd_q,        rd_d;
    logic [REG_AW-1:0] rs_q,        rs_d;
    logic [REG_AW-1:0] rt_q,        rt_d;
    logic              rw_q,        rw_d;
    logic              src2_rt_q,   src2_rt_d;

    logic [DATA_W-1:0] rs_fwd, rt_fwd, rs_snoop, rt_snoop, imm_ext;
    logic              capture, hold;

    assign in_ready = !valid_q || out_ready;
    assign capture  = in_valid && in_ready;
    assign hold     = valid_q && !out_ready;
    assign imm_ext  = {{(DATA_W-16){in_sign_ext & in_imm[15]}}, in_imm};

    fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rs_fwd (
        .addr(in_rs_addr), .rf_data(in_rs_data),
        .exmem_reg_write(exmem_reg_write), .exmem_rd_addr(exmem_rd_addr), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd_addr(memwb_rd_addr), .memwb_data(memwb_data),
        .data(rs_fwd)
    );

    fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rt_fwd (
        .addr(in_rt_addr), .rf_data(in_rt_data),
        .exmem_reg_write(exmem_reg_write), .exmem_rd_addr(exmem_rd_addr), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd_addr(memwb_rd_addr), .memwb_data(memwb_data),
        .data(rt_fwd)
    );

    // While holding, only writeback is snooped; the held value is the fall-back "register file".
    fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rs_snoop (
        .addr(rs_q), .rf_data(src1_q),
        .exmem_reg_write(1'b0), .exmem_rd_addr('0), .exmem_result('0),
        .memwb_reg_write(memwb_reg_write), .memwb_rd_addr(memwb_rd_addr), .memwb_data(memwb_data),
        .data(rs_snoop)
    );

    fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rt_snoop (
        .addr(rt_q), .rf_data(store_q),
        .exmem_reg_write(1'b0), .exmem_rd_addr('0), .exmem_result('0),
        .memwb_reg_write(memwb_reg_write), .memwb_rd_addr(memwb_rd_addr), .memwb_data(memwb_data),
        .data(rt_snoop)
    );

    always_comb begin
        valid_d   = valid_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        store_d   = store_q;
        ctrl_d    = ctrl_q;
        rd_d      = rd_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rw_d      = rw_q;
        src2_rt_d = src2_rt_q;

        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d   = 1'b1;
            src1_d    = rs_fwd;
            src2_d    = in_alu_src ? imm_ext : rt_fwd;
            store_d   = rt_fwd;
            ctrl_d    = in_alu_ctrl;
            rd_d      = in_rd_addr;
            rs_d      = in_rs_addr;
            rt_d      = in_rt_addr;
            rw_d      = in_reg_write;
            src2_rt_d = !in_alu_src;
        end else if (hold) begin
            src1_d  = rs_snoop;
            store_d = rt_snoop;
            if (src2_rt_q) begin
                src2_d = rt_snoop;
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // NOTE: reset is sampled on the clock edge (synchronous) and state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            src1_q    <= '0;
            src2_q    <= '0;
            store_q   <= '0;
            ctrl_q    <= '0;
            rd_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rw_q      <= 1'b0;
            src2_rt_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            store_q   <= store_d;
            ctrl_q    <= ctrl_d;
            rd_q      <= rd_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rw_q      <= rw_d;
            src2_rt_q <= src2_rt_d;
        end
    end

    assign out_valid      = valid_q;
    assign src1           = src1_q;
    assign src2           = src2_q;
    assign ALU_control    = ctrl_q;
    assign out_rd_addr    = rd_q;
    assign out_reg_write  = valid_q && rw_q;
    assign out_store_data = store_q;

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] issue_cnt_q, issue_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Counters wrap naturally and are deliberately untouched by flush.
    always_comb begin
        issue_cnt_d = issue_cnt_q + 32'(valid_q && out_ready);
        stall_cnt_d = stall_cnt_q + 32'(hold);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_issue_cnt = issue_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_issue_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed plan steps, then random traffic
// against a transaction-level reference model.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_alu_src, in_sign_ext, in_reg_write, flush;
    logic [4:0]  in_rs_addr, in_rt_addr, in_rd_addr, exmem_rd_addr, memwb_rd_addr;
    logic [31:0] in_rs_data, in_rt_data, exmem_result, memwb_data;
    logic [15:0] in_imm;
    logic [3:0]  in_alu_ctrl;
    logic        exmem_reg_write, memwb_reg_write, out_ready;
    logic        in_ready, out_valid, out_reg_write;
    logic [31:0] src1, src2, out_store_data, perf_issue_cnt, perf_stall_cnt;
    logic [3:0]  ALU_control;
    logic [4:0]  out_rd_addr;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_rd_addr(in_rd_addr),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
        .in_alu_src(in_alu_src), .in_sign_ext(in_sign_ext), .in_alu_ctrl(in_alu_ctrl),
        .in_reg_write(in_reg_write), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd_addr(exmem_rd_addr), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd_addr(memwb_rd_addr), .memwb_data(memwb_data),
        .out_valid(out_valid), .out_ready(out_ready), .src1(src1), .src2(src2),
        .ALU_control(ALU_control), .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write),
        .out_store_data(out_store_data), .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: the instruction currently presented to the ALU.
    typedef struct {
        bit          valid;
        logic [31:0] a, b, store;
        logic [3:0]  op;
        logic [4:0]  rd, rs, rt;
        bit          wr, b_is_imm;
    } slot_t;

    slot_t       m;
    logic [31:0] m_issue, m_stall;
    bit          rst_seen = 0;
    logic [3:0]  codes [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Value the ALU should see for a register read at issue time.
    function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] rf);
        if (a == 0) return 32'd0;
        if (exmem_reg_write && exmem_rd_addr == a) return exmem_result;
        if (memwb_reg_write && memwb_rd_addr == a) return memwb_data;
        return rf;
    endfunction

    task automatic model_edge();
        bit took, stalled;
        if (!rst_n) begin
            m = '{valid: 0, a: 0, b: 0, store: 0, op: 0, rd: 0, rs: 0, rt: 0, wr: 0, b_is_imm: 0};
            m_issue = 0;
            m_stall = 0;
            rst_seen = 1;
            return;
        end
        took    = m.valid && out_ready;
        stalled = m.valid && !out_ready;
        m_issue += took ? 1 : 0;
        m_stall += stalled ? 1 : 0;
        if (flush) begin
            m.valid = 0;
        end else if (in_valid && (!m.valid || out_ready)) begin
            m.valid    = 1;
            m.a        = operand(in_rs_addr, in_rs_data);
            m.store    = operand(in_rt_addr, in_rt_data);
            m.b        = in_alu_src ? (in_sign_ext ? 32'($signed(in_imm)) : 32'(in_imm)) : m.store;
            m.op       = in_alu_ctrl;
            m.rd       = in_rd_addr;
            m.rs       = in_rs_addr;
            m.rt       = in_rt_addr;
            m.wr       = in_reg_write;
            m.b_is_imm = in_alu_src;
        end else if (stalled) begin
            if (memwb_reg_write && memwb_rd_addr != 0) begin
                if (memwb_rd_addr == m.rs) m.a = memwb_data;
                if (memwb_rd_addr == m.rt) begin
                    m.store = memwb_data;
                    if (!m.b_is_imm) m.b = memwb_data;
                end
            end
        end else begin
            m.valid = 0;
        end
    endtask

    task automatic check_regs();
        chk("out_valid", 32'(out_valid), 32'(m.valid));
        chk("out_reg_write", 32'(out_reg_write), 32'(m.valid && m.wr));
        if (m.valid) begin
            chk("src1", src1, m.a);
            chk("src2", src2, m.b);
            chk("store_data", out_store_data, m.store);
            chk("alu_control", 32'(ALU_control), 32'(m.op));
            chk("rd_addr", 32'(out_rd_addr), 32'(m.rd));
        end
`ifdef ALU_ISSUE_PERF_EN
        chk("perf_issue", perf_issue_cnt, m_issue);
        chk("perf_stall", perf_stall_cnt, m_stall);
`else
        chk("perf_issue_tied", perf_issue_cnt, 32'd0);
        chk("perf_stall_tied", perf_stall_cnt, 32'd0);
`endif
    endtask

    // One clock: ready checked mid-cycle, model advanced, registered outputs checked after the edge.
    task automatic tick();
        @(negedge clk);
        if (rst_seen) chk("in_ready", 32'(in_ready), 32'(!m.valid || out_ready));
        model_edge();
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic set_idle();
        in_valid = 0; in_rs_addr = 0; in_rt_addr = 0; in_rd_addr = 0;
        in_rs_data = 0; in_rt_data = 0; in_imm = 0; in_alu_src = 0; in_sign_ext = 0;
        in_alu_ctrl = 0; in_reg_write = 0; flush = 0;
        exmem_reg_write = 0; exmem_rd_addr = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd_addr = 0; memwb_data = 0;
        out_ready = 1;
    endtask

    task automatic randomize_inputs();
        rst_n           = ($urandom_range(99) != 0);
        in_valid        = ($urandom_range(9) < 7);
        in_rs_addr      = 5'($urandom_range(7));
        in_rt_addr      = 5'($urandom_range(7));
        in_rd_addr      = 5'($urandom_range(31));
        in_rs_data      = $urandom;
        in_rt_data      = $urandom;
        in_imm          = 16'($urandom);
        in_alu_src      = 1'($urandom);
        in_sign_ext     = 1'($urandom);
        in_alu_ctrl     = codes[$urandom_range(5)];
        in_reg_write    = 1'($urandom);
        flush           = ($urandom_range(19) == 0);
        exmem_reg_write = 1'($urandom);
        exmem_rd_addr   = 5'($urandom_range(7));
        exmem_result    = $urandom;
        memwb_reg_write = 1'($urandom);
        memwb_rd_addr   = 5'($urandom_range(7));
        memwb_data      = $urandom;
        out_ready       = ($urandom_range(9) < 6);
    endtask

    initial begin
        int          run;
        logic [31:0] base;

        set_idle();

        // Reset with a pending instruction
        rst_n = 0; in_valid = 1; in_rs_addr = 5'd3; in_rs_data = 32'h1234;
        tick();
        tick();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_src1", src1, 32'd0);
        chk("reset_src2", src2, 32'd0);
        rst_n = 1; set_idle();
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        tick();

        // Immediate, sign- then zero-extended, back to back
        in_valid = 1; in_rs_addr = 5'd3; in_rs_data = 32'd5; in_imm = 16'hFFF0;
        in_alu_src = 1; in_sign_ext = 1; in_alu_ctrl = 4'b0010;
        tick();
        chk("imm_src1", src1, 32'd5);
        chk("imm_sext", src2, 32'hFFFF_FFF0);
        chk("imm_ctrl", 32'(ALU_control), 32'h2);
        in_sign_ext = 0;
        tick();
        chk("imm_zext", src2, 32'h0000_FFF0);

        // Forward priority and register zero
        in_alu_src = 0; in_rs_addr = 5'd7; in_rs_data = 32'h7777;
        exmem_reg_write = 1; exmem_rd_addr = 5'd7; exmem_result = 32'hAAAA;
        memwb_reg_write = 1; memwb_rd_addr = 5'd7; memwb_data = 32'hBBBB;
        tick();
        chk("fwd_exmem_wins", src1, 32'hAAAA);
        in_rs_addr = 5'd0; exmem_rd_addr = 5'd0; memwb_rd_addr = 5'd0;
        tick();
        chk("fwd_r0_zero", src1, 32'd0);
        set_idle();
        tick();

        // Hold with writeback snoop
        in_valid = 1; in_rt_addr = 5'd4; in_rt_data = 32'h11; in_alu_src = 0;
        tick();
        chk("hold_capture", src2, 32'h11);
        base = m_stall;
        in_rt_data = 32'h99; out_ready = 0;
        tick();
        chk("hold_in_ready_c1", 32'(in_ready), 32'd0);
        memwb_reg_write = 1; memwb_rd_addr = 5'd4; memwb_data = 32'h22;
        tick();
        chk("hold_snoop_src2", src2, 32'h22);
        chk("hold_snoop_store", out_store_data, 32'h22);
        memwb_reg_write = 0;
        tick();
        chk("hold_in_ready_c3", 32'(in_ready), 32'd0);
        chk("hold_src2_kept", src2, 32'h22);
`ifdef ALU_ISSUE_PERF_EN
        chk("hold_stall_cnt", perf_stall_cnt, base + 32'd3);
`endif
        set_idle();
        tick();

        // Flush beats capture, then normal acceptance
        in_valid = 1; in_reg_write = 1; in_rd_addr = 5'd9; out_ready = 0;
        tick();
        flush = 1; in_rd_addr = 5'd10;
        tick();
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_reg_write", 32'(out_reg_write), 32'd0);
        flush = 0; in_rd_addr = 5'd11;
        tick();
        chk("after_flush_valid", 32'(out_valid), 32'd1);
        chk("after_flush_rd", 32'(out_rd_addr), 32'd11);
        set_idle();
        tick();

        // Throughput: 10 back-to-back instructions
        base = m_issue;
        run = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1; in_rs_addr = 5'(i + 1); in_rs_data = 32'(i * 3); in_alu_ctrl = codes[i % 6];
            tick();
            if (out_valid === 1'b1) run++;
        end
        set_idle();
        tick();
        chk("throughput_run", 32'(run), 32'd10);
`ifdef ALU_ISSUE_PERF_EN
        chk("throughput_issue_cnt", perf_issue_cnt, base + 32'd10);
`endif

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            randomize_inputs();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
